forward_unit: RTL and testbench

FORWARD_UNIT -- requirements
Module: forward_unit

---
 rtl/forward_unit_pkg.sv | 22 ++
 rtl/forward_unit_fwd_match.sv | 40 ++++
 rtl/forward_unit.sv | 93 +++++++++
 tb/tb_forward_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/forward_unit_pkg.sv
// Shared types for the EX-stage forwarding unit: producer slot record and helpers.
// SLOT_DW/SLOT_RW are the stored slot widths and must be >= the DW/RW used by forward_unit.
package forward_unit_pkg;

   localparam int SLOT_DW = 32;
   localparam int SLOT_RW = 5;

   localparam logic [SLOT_RW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic               valid;
      logic [SLOT_RW-1:0] dst;
      logic [SLOT_DW-1:0] data;
      logic               load;
   } slot_t;

   // Register 0 is hard-wired, so it never matches a producer.
   function automatic logic slot_hit(input slot_t s, input logic [SLOT_RW-1:0] idx);
      return s.valid && (s.dst == idx) && (s.dst != REG_ZERO);
   endfunction

endpackage

// File: rtl/forward_unit_fwd_match.sv
// Per-operand forwarding decision: MEM beats WB; a MEM load match stalls instead of forwarding.
module fwd_match
   import forward_unit_pkg::*;
#(
   parameter int DW = SLOT_DW,
   parameter int RW = SLOT_RW
) (
   input  logic [RW-1:0] idx,
   input  slot_t         mem_slot,
   input  slot_t         wb_slot,
   output logic          fwd,
   output logic [DW-1:0] fwd_data,
   output logic          stall
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = slot_hit(mem_slot, SLOT_RW'(idx));
   assign wb_hit  = slot_hit(wb_slot, SLOT_RW'(idx));

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      fwd      = 1'b0;
      fwd_data = '0;
      stall    = 1'b0;
      if (mem_hit) begin
         if (mem_slot.load) begin
            stall = 1'b1;
         end else begin
            fwd      = 1'b1;
            fwd_data = DW'(mem_slot.data);
         end
      end else if (wb_hit) begin
         fwd      = 1'b1;
         fwd_data = DW'(wb_slot.data);
      end
   end

endmodule

// File: rtl/forward_unit.sv
// EX-stage forwarding unit with MEM/WB producer slots and load-use stall detection.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module forward_unit
   import forward_unit_pkg::*;
#(
   parameter int DW = SLOT_DW,
   parameter int RW = SLOT_RW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic [RW-1:0] ex_rs,
   input  logic [RW-1:0] ex_rt,
   input  logic          ex_wreg,
   input  logic [RW-1:0] ex_wdst,
   input  logic [DW-1:0] ex_wdata,
   input  logic          ex_load,
   input  logic [DW-1:0] mem_rdata,
   output logic          forward_rs,
   output logic [DW-1:0] forward_rs_data,
   output logic          forward_rt,
   output logic [DW-1:0] forward_rt_data,
   output logic          stall,
   output logic [31:0]   stall_cnt
);

   slot_t mem_q, wb_q;
   slot_t mem_d, wb_d;
   logic  stall_rs, stall_rt;

   fwd_match #(.DW(DW), .RW(RW)) u_match_rs (
      .idx      (ex_rs),
      .mem_slot (mem_q),
      .wb_slot  (wb_q),
      .fwd      (forward_rs),
      .fwd_data (forward_rs_data),
      .stall    (stall_rs)
   );

   fwd_match #(.DW(DW), .RW(RW)) u_match_rt (
      .idx      (ex_rt),
      .mem_slot (mem_q),
      .wb_slot  (wb_q),
      .fwd      (forward_rt),
      .fwd_data (forward_rt_data),
      .stall    (stall_rt)
   );

   assign stall = stall_rs | stall_rt;

   // A load's result only exists once it reaches MEM, so WB captures mem_rdata for it.
   always_comb begin
      wb_d = mem_q;
      if (mem_q.load) begin
         wb_d.data = SLOT_DW'(mem_rdata);
      end
      mem_d = '0;
      if (!stall) begin
         mem_d.valid = ex_wreg;
         mem_d.dst   = SLOT_RW'(ex_wdst);
         mem_d.data  = SLOT_DW'(ex_wdata);
         mem_d.load  = ex_load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state registers use non-blocking assignments so all slots update together.
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!freeze) begin
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef FWD_STALL_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (stall && !freeze && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign stall_cnt = cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_forward_unit.sv
// Directed scoreboard bench for forward_unit; counter expectations follow FWD_STALL_CNT_EN.
module tb_forward_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic [4:0]  ex_rs, ex_rt, ex_wdst;
   logic        ex_wreg, ex_load;
   logic [31:0] ex_wdata, mem_rdata;
   logic        forward_rs, forward_rt, stall;
   logic [31:0] forward_rs_data, forward_rt_data, stall_cnt;

   typedef struct {
      logic        frs;
      logic [31:0] drs;
      logic        frt;
      logic [31:0] drt;
      logic        stl;
      logic [31:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    total  = 0;
   int    passed = 0;

   always #5 clk = ~clk;

   forward_unit #(.DW(32), .RW(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .ex_rs           (ex_rs),
      .ex_rt           (ex_rt),
      .ex_wreg         (ex_wreg),
      .ex_wdst         (ex_wdst),
      .ex_wdata        (ex_wdata),
      .ex_load         (ex_load),
      .mem_rdata       (mem_rdata),
      .forward_rs      (forward_rs),
      .forward_rs_data (forward_rs_data),
      .forward_rt      (forward_rt),
      .forward_rt_data (forward_rt_data),
      .stall           (stall),
      .stall_cnt       (stall_cnt)
   );

   function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef FWD_STALL_CNT_EN
      return n;
`else
      return 32'd0 & n;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic expect_out(input string tag, input logic frs, input logic [31:0] drs,
                             input logic frt, input logic [31:0] drt,
                             input logic stl, input logic [31:0] cnt);
      exp_t e;
      e.frs = frs; e.drs = drs; e.frt = frt; e.drt = drt; e.stl = stl; e.cnt = exp_cnt(cnt);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic compare_out();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".fwd_rs"},  {31'd0, forward_rs}, {31'd0, e.frs});
      check({t, ".rs_data"}, forward_rs_data,     e.drs);
      check({t, ".fwd_rt"},  {31'd0, forward_rt}, {31'd0, e.frt});
      check({t, ".rt_data"}, forward_rt_data,     e.drt);
      check({t, ".stall"},   {31'd0, stall},      {31'd0, e.stl});
      check({t, ".cnt"},     stall_cnt,           e.cnt);
   endtask

   // Drive one EX-stage cycle at the falling edge; outputs are sampled before the rising edge.
   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic wreg,
                        input logic [4:0] wdst, input logic [31:0] wdata, input logic load,
                        input logic [31:0] rdata, input logic frz);
      @(negedge clk);
      ex_rs = rs; ex_rt = rt; ex_wreg = wreg; ex_wdst = wdst;
      ex_wdata = wdata; ex_load = load; mem_rdata = rdata; freeze = frz;
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; ex_rs = '0; ex_rt = '0; ex_wreg = 1'b0;
      ex_wdst = '0; ex_wdata = '0; ex_load = 1'b0; mem_rdata = '0;

      #2;
      expect_out("reset", 0, 0, 0, 0, 0, 0);
      compare_out();
      drive(5'd3, 5'd3, 1'b1, 5'd3, 32'h99, 1'b1, 32'h0, 1'b0);
      #2;
      expect_out("in_reset", 0, 0, 0, 0, 0, 0);
      compare_out();
      @(negedge clk);
      rst = 1'b0;

      // MEM priority over WB
      drive(5'd0, 5'd0, 1'b1, 5'd3, 32'h11, 1'b0, 32'h0, 1'b0);
      expect_out("mp_c1", 0, 0, 0, 0, 0, 0); #2 compare_out();
      drive(5'd0, 5'd3, 1'b1, 5'd3, 32'h22, 1'b0, 32'h0, 1'b0);
      expect_out("mp_c2", 0, 0, 1, 32'h11, 0, 0); #2 compare_out();
      drive(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("mp_c3", 1, 32'h22, 0, 0, 0, 0); #2 compare_out();

      // WB forwarding
      drive(5'd0, 5'd0, 1'b1, 5'd5, 32'h7, 1'b0, 32'h0, 1'b0);
      expect_out("wb_c1", 0, 0, 0, 0, 0, 0); #2 compare_out();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("wb_c2", 0, 0, 0, 0, 0, 0); #2 compare_out();
      drive(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("wb_c3", 0, 0, 1, 32'h7, 0, 0); #2 compare_out();

      // Load-use: one stall cycle, then forward the loaded value from WB
      drive(5'd0, 5'd0, 1'b1, 5'd4, 32'h1234, 1'b1, 32'h0, 1'b0);
      expect_out("lu_load", 0, 0, 0, 0, 0, 0); #2 compare_out();
      drive(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'hDEAD, 1'b0);
      expect_out("lu_stall", 0, 0, 0, 0, 1, 0); #2 compare_out();
      drive(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("lu_fwd", 1, 32'hDEAD, 0, 0, 0, 1); #2 compare_out();

      // Register 0 never forwards
      drive(5'd0, 5'd0, 1'b1, 5'd0, 32'h55, 1'b0, 32'h0, 1'b0);
      expect_out("r0_c1", 0, 0, 0, 0, 0, 1); #2 compare_out();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("r0_mem", 0, 0, 0, 0, 0, 1); #2 compare_out();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("r0_wb", 0, 0, 0, 0, 0, 1); #2 compare_out();

      // Freeze during a load-use stall, with rs == rt
      drive(5'd0, 5'd0, 1'b1, 5'd6, 32'h0, 1'b1, 32'h0, 1'b0);
      expect_out("fz_load", 0, 0, 0, 0, 0, 1); #2 compare_out();
      for (int i = 0; i < 3; i++) begin
         drive(5'd6, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 32'hBEEF, 1'b1);
         expect_out($sformatf("fz_hold%0d", i), 0, 0, 0, 0, 1, 1); #2 compare_out();
      end
      drive(5'd6, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 32'hBEEF, 1'b0);
      expect_out("fz_release", 0, 0, 0, 0, 1, 1); #2 compare_out();
      drive(5'd6, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("fz_fwd", 1, 32'hBEEF, 1, 32'hBEEF, 0, 2); #2 compare_out();

      // Reset while MEM holds a load and the consumer is stalled
      drive(5'd0, 5'd0, 1'b1, 5'd8, 32'h0, 1'b1, 32'h0, 1'b0);
      expect_out("rs_load", 0, 0, 0, 0, 0, 2); #2 compare_out();
      drive(5'd8, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'hAAAA, 1'b0);
      expect_out("rs_stall", 0, 0, 0, 0, 1, 2); #2 compare_out();
      rst = 1'b1;
      #1;
      expect_out("rs_async", 0, 0, 0, 0, 0, 0); compare_out();
      @(negedge clk);
      rst = 1'b0;
      drive(5'd8, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("rs_after", 0, 0, 0, 0, 0, 0); #2 compare_out();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
